gen_dir_siguiente: RTL and testbench

//  Next-address generator feeding ProgramCounter.dirin; consumes ProgramCounter.dirout.

---
 rtl/gen_dir_siguiente_pkg.sv | 20 ++
 rtl/gen_dir_siguiente_if.sv | 36 +++
 rtl/gen_dir_siguiente_sumador_dir.sv | 12 +
 rtl/gen_dir_siguiente.sv | 112 +++++++++++
 tb/tb_gen_dir_siguiente.sv | 139 +++++++++++++
 5 files changed

// File: rtl/gen_dir_siguiente_pkg.sv
// Shared types and constants for the next-address generator.
package gen_dir_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned FLUSH_W = 2;

  localparam logic [ADDR_W-1:0] INSTR_BYTES = 64'd4;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A target is misaligned when its low two bits are not zero.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/gen_dir_siguiente_if.sv
// Bus between the core (branch unit + PC register) and the next-address generator.
// Carries instr_cnt only when INSTR_CNT_EN is defined.
interface gen_dir_siguiente_if;
  import gen_dir_pkg::*;

  logic [ADDR_W-1:0] dirout;
  logic              stall;
  logic              br_taken;
  logic              br_reg;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_dir;
  logic [ADDR_W-1:0] dirin;
  logic              pc_en;
  logic              fetch_valid;
  logic              err_align;
`ifdef INSTR_CNT_EN
  logic [63:0]       instr_cnt;
`endif

  modport master (
    output dirout, stall, br_taken, br_reg, br_off, br_dir,
`ifdef INSTR_CNT_EN
    input  instr_cnt,
`endif
    input  dirin, pc_en, fetch_valid, err_align
  );

  modport slave (
    input  dirout, stall, br_taken, br_reg, br_off, br_dir,
`ifdef INSTR_CNT_EN
    output instr_cnt,
`endif
    output dirin, pc_en, fetch_valid, err_align
  );

endinterface

// File: rtl/gen_dir_siguiente_sumador_dir.sv
// 64-bit address adder, wraps modulo 2^64.
module sumador_dir
  import gen_dir_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] sum_c
);

  assign sum_c = a + b;

endmodule

// File: rtl/gen_dir_siguiente.sv
// Next-address generator for the PC register: PC+4, branch target, stall hold
// and post-branch flush bubbles. Optional INSTR_CNT_EN adds an executed-instruction counter.
module gen_dir_siguiente
  import gen_dir_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC = 64'h0,
  parameter int unsigned       FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  gen_dir_siguiente_if.slave bus
);

  state_e               state_q, state_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 err_align_q, err_align_d;

  logic [ADDR_W-1:0]    pc_plus4_c;
  logic [ADDR_W-1:0]    pc_rel_c;
  logic [ADDR_W-1:0]    off_sh_c;
  logic [ADDR_W-1:0]    target_c;
  logic [ADDR_W-1:0]    dirin_c;
  logic                 pc_en_c;
  logic                 fetch_valid_c;

  // Word offset to byte offset; top two bits fall off.
  assign off_sh_c = bus.br_off << 2;

  sumador_dir u_sum_seq (.a(bus.dirout), .b(INSTR_BYTES), .sum_c(pc_plus4_c));
  sumador_dir u_sum_rel (.a(bus.dirout), .b(off_sh_c),    .sum_c(pc_rel_c));

  assign target_c = bus.br_reg ? bus.br_dir : pc_rel_c;

  // State, flush counter and sticky alignment error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RST;
      flush_cnt_q <= '0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      err_align_q <= err_align_d;
    end
  end

  // Next-state and next-address selection.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    err_align_d   = err_align_q;
    dirin_c       = RESET_VEC;
    pc_en_c       = 1'b1;
    fetch_valid_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.stall) begin
          dirin_c = bus.dirout;
          pc_en_c = 1'b0;
        end else if (bus.br_taken) begin
          dirin_c       = target_c;
          fetch_valid_c = 1'b1;
          if (misaligned(target_c)) err_align_d = 1'b1;
          if (FLUSH_CYC > 0) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_W'(FLUSH_CYC - 1);
          end
        end else begin
          dirin_c       = pc_plus4_c;
          fetch_valid_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (bus.stall) begin
          dirin_c = bus.dirout;
          pc_en_c = 1'b0;
        end else begin
          dirin_c = pc_plus4_c;
          if (flush_cnt_q == '0) state_d = ST_RUN;
          else                   flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.dirin       = dirin_c;
  assign bus.pc_en       = pc_en_c;
  assign bus.fetch_valid = fetch_valid_c;
  assign bus.err_align   = err_align_q;

`ifdef INSTR_CNT_EN
  logic [63:0] instr_cnt_q, instr_cnt_d;

  // Count instructions that actually execute.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (fetch_valid_c && !bus.stall) instr_cnt_d = instr_cnt_q + 64'd1;
  end

  // Executed-instruction counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_cnt_q <= '0;
    else     instr_cnt_q <= instr_cnt_d;
  end

  assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_gen_dir_siguiente.sv
// Closed-loop bench: behavioural PC register + gen_dir_siguiente, scoreboard checking.
module tb_gen_dir_siguiente;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_q = 64'h0;
  logic        force_en = 1'b0;
  logic [63:0] force_val = 64'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] dirout;
    logic [63:0] dirin;
    logic        pc_en;
    logic        fv;
    logic        err;
    logic [63:0] icnt;
  } exp_t;

  exp_t sb_q[$];

  gen_dir_siguiente_if bus ();

  gen_dir_siguiente #(
    .RESET_VEC (64'h100),
    .FLUSH_CYC (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ProgramCounter; force_en overrides its output to reach odd addresses.
  always @(posedge clk) if (bus.pc_en) pc_q <= bus.dirin;
  assign bus.dirout = force_en ? force_val : pc_q;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a response, pop and compare.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "dirout",      bus.dirout,             e.dirout);
      chk(e.name, "dirin",       bus.dirin,              e.dirin);
      chk(e.name, "pc_en",       64'(bus.pc_en),         64'(e.pc_en));
      chk(e.name, "fetch_valid", 64'(bus.fetch_valid),   64'(e.fv));
      chk(e.name, "err_align",   64'(bus.err_align),     64'(e.err));
`ifdef INSTR_CNT_EN
      chk(e.name, "instr_cnt",   bus.instr_cnt,          e.icnt);
`endif
    end
  end

  // Drive one cycle of inputs just after the edge and queue the expected response.
  task automatic cyc(input string nm, input logic r, input logic st, input logic bt,
                     input logic brg, input logic [63:0] off, input logic [63:0] dir,
                     input logic fe, input logic [63:0] fval,
                     input logic [63:0] e_dirout, input logic [63:0] e_dirin,
                     input logic e_pc_en, input logic e_fv, input logic e_err,
                     input logic [63:0] e_icnt);
    exp_t e;
    #1;
    rst          = r;
    bus.stall    = st;
    bus.br_taken = bt;
    bus.br_reg   = brg;
    bus.br_off   = off;
    bus.br_dir   = dir;
    force_en     = fe;
    force_val    = fval;
    e.name   = nm;
    e.dirout = e_dirout;
    e.dirin  = e_dirin;
    e.pc_en  = e_pc_en;
    e.fv     = e_fv;
    e.err    = e_err;
    e.icnt   = e_icnt;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_reg = 1'b0;
    bus.br_off = '0;  bus.br_dir = '0;
    rst = 1'b1;
    @(posedge clk);
    //   name        rst st bt brg off                     dir       fe fval                    dirout                  dirin     pe fv er icnt
    cyc("rst_hold",  1, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h100,                64'h100,  1, 0, 0, 64'd0);
    cyc("rst_state", 0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h100,                64'h100,  1, 0, 0, 64'd0);
    cyc("seq_100",   0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h100,                64'h104,  1, 1, 0, 64'd0);
    cyc("seq_104",   0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h104,                64'h108,  1, 1, 0, 64'd1);
    cyc("br_back",   0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,   0, 64'h0,                  64'h108,                64'h100,  1, 1, 0, 64'd2);
    cyc("flush",     0, 0, 1, 0, 64'h40,                 64'h0,    0, 64'h0,                  64'h100,                64'h104,  1, 0, 0, 64'd3);
    cyc("post_fl",   0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h104,                64'h108,  1, 1, 0, 64'd3);
    cyc("seq_108",   0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h108,                64'h10C,  1, 1, 0, 64'd4);
    cyc("stall_1",   0, 1, 1, 0, 64'h10,                 64'h0,    0, 64'h0,                  64'h10C,                64'h10C,  0, 0, 0, 64'd5);
    cyc("stall_2",   0, 1, 1, 0, 64'h10,                 64'h0,    0, 64'h0,                  64'h10C,                64'h10C,  0, 0, 0, 64'd5);
    cyc("stall_3",   0, 1, 1, 0, 64'h10,                 64'h0,    0, 64'h0,                  64'h10C,                64'h10C,  0, 0, 0, 64'd5);
    cyc("unstall",   0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h10C,                64'h110,  1, 1, 0, 64'd5);
    cyc("br_reg",    0, 0, 1, 1, 64'h0,                  64'h2002, 0, 64'h0,                  64'h110,                64'h2002, 1, 1, 0, 64'd6);
    cyc("fl_stall",  0, 1, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h2002,               64'h2002, 0, 0, 1, 64'd7);
    cyc("fl_resume", 0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h2002,               64'h2006, 1, 0, 1, 64'd7);
    cyc("seq_2006",  0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h2006,               64'h200A, 1, 1, 1, 64'd7);
    cyc("wrap",      0, 0, 0, 0, 64'h0,                  64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,    1, 1, 1, 64'd8);
    cyc("seq_0",     0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h0,                  64'h4,    1, 1, 1, 64'd9);
    cyc("off_trunc", 0, 0, 1, 0, 64'h4000_0000_0000_0001, 64'h0,   0, 64'h0,                  64'h4,                  64'h8,    1, 1, 1, 64'd10);
    cyc("rst_flush", 1, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h8,                  64'h100,  1, 0, 0, 64'd0);
    cyc("rst_rel",   0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h100,                64'h100,  1, 0, 0, 64'd0);
    cyc("run_again", 0, 0, 0, 0, 64'h0,                  64'h0,    0, 64'h0,                  64'h100,                64'h104,  1, 1, 0, 64'd0);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
